// File: rtl/miri_pkg.sv
// Shared fetch-side types and constants.
// Holds the fetch FSM encoding and the IF/ID bundle layout.
package miri_pkg;

  localparam int LINE_BITS = 128;
  localparam int WORD_BITS = 32;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_BITS-1:0] instr;
    logic [31:0]          pc;
    logic                 valid;
  } if_id_t;

  // Word-aligned form of a redirect address.
  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Instruction line storage with hit detection and word select.
// FETCH_ICACHE_EN: 4-line direct-mapped cache, else one line buffer.
module icache_array
  import miri_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:2]          addr,
  input  logic                 wr_en,
  input  logic [31:4]          wr_addr,
  input  logic [LINE_BITS-1:0] wr_line,
  output logic                 hit,
  output logic [WORD_BITS-1:0] word
);

  logic [LINE_BITS-1:0] sel_line;

`ifdef FETCH_ICACHE_EN

  logic [3:0]           valid;
  logic [25:0]          tags  [4];
  logic [LINE_BITS-1:0] lines [4];
  logic [1:0]           idx;
  logic [1:0]           widx;

  assign idx  = addr[5:4];
  assign widx = wr_addr[5:4];

  // Valid bits: cleared on reset, set by a completed fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data storage, written only by a completed fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[widx]  <= wr_addr[31:6];
      lines[widx] <= wr_line;
    end
  end

  // Lookup on the indexed line.
  always_comb begin
    hit      = valid[idx] && (tags[idx] == addr[31:6]);
    sel_line = lines[idx];
  end

`else

  logic                 valid;
  logic [27:0]          tag;
  logic [LINE_BITS-1:0] line;

  // Buffer valid bit: cleared on reset, set by a completed fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
    end
  end

  // Buffer tag and data, replaced by every fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag  <= wr_addr[31:4];
      line <= wr_line;
    end
  end

  // Lookup against the single buffered line.
  always_comb begin
    hit      = valid && (tag == addr[31:4]);
    sel_line = line;
  end

`endif

  // Word select inside the line.
  always_comb begin
    word = sel_line[31:0];
    unique case (addr[3:2])
      2'd0: word = sel_line[31:0];
      2'd1: word = sel_line[63:32];
      2'd2: word = sel_line[95:64];
      2'd3: word = sel_line[127:96];
      default: word = sel_line[31:0];
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, miss FSM, line fill and IF/ID register.
// Storage built as a cache when FETCH_ICACHE_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = miri_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = miri_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_fetch,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata,
  output logic [31:0]  instruction,
  output logic [31:0]  pc_out,
  output logic         instr_valid,
  output logic         block_pipe_instr_cache
);

  import miri_pkg::*;

  fetch_state_t   state;
  logic [31:0]    pc;
  logic [31:4]    fill_line;
  if_id_t         out_q;
  logic           hit;
  logic [31:0]    word;
  logic           idle;
  logic           hit_idle;
  logic           fill_we;
  logic           unused_tgt;

  assign unused_tgt = ^branch_target[1:0];

  assign idle     = (state == IDLE);
  assign hit_idle = idle && hit;
  assign fill_we  = (state == REQ) && mem_ready && !reset;

  icache_array u_icache (
    .clk     (clk),
    .reset   (reset),
    .addr    (pc[31:2]),
    .wr_en   (fill_we),
    .wr_addr (fill_line),
    .wr_line (mem_rdata),
    .hit     (hit),
    .word    (word)
  );

  // Memory side and stall indication; both quiet in reset.
  always_comb begin
    mem_req  = (state == REQ) && !reset;
    mem_addr = idle ? {pc[31:4], 4'b0000}
                    : {fill_line, 4'b0000};
    block_pipe_instr_cache = !reset && (!idle || !hit);
  end

  // Miss FSM; the fill line is latched so redirects cannot move it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fill_line <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!hit) begin
            state     <= REQ;
            fill_line <= pc[31:4];
          end
        end
        REQ: begin
          if (mem_ready) state <= FILL;
        end
        FILL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // PC: redirect wins, otherwise advance only on a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (en_fetch) begin
      if (branch_taken) begin
        pc <= word_align(branch_target);
      end else if (hit_idle) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // IF/ID register: real instruction on a hit, bubble otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q.instr <= NOP_INSTR;
      out_q.pc    <= '0;
      out_q.valid <= 1'b0;
    end else if (en_fetch) begin
      out_q.pc <= pc;
      if (hit_idle && !branch_taken) begin
        out_q.instr <= word;
        out_q.valid <= 1'b1;
      end else begin
        out_q.instr <= NOP_INSTR;
        out_q.valid <= 1'b0;
      end
    end
  end

  assign instruction = out_q.instr;
  assign pc_out      = out_q.pc;
  assign instr_valid = out_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage.
// Memory word at address a is a ^ 32'hA5A5_0000.
module tb_fetch_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         en_fetch;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [31:0]  instruction;
  logic [31:0]  pc_out;
  logic         instr_valid;
  logic         block_pipe_instr_cache;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   lat      = 0;
  int   req_cnt  = 0;
  int   fill_cnt = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_1000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .en_fetch               (en_fetch),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_ready              (mem_ready),
    .mem_rdata              (mem_rdata),
    .instruction            (instruction),
    .pc_out                 (pc_out),
    .instr_valid            (instr_valid),
    .block_pipe_instr_cache (block_pipe_instr_cache)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0000};
    return {instr_of(b + 32'd12), instr_of(b + 32'd8),
            instr_of(b + 32'd4),  instr_of(b)};
  endfunction

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = instr_of(a);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_sb(input int n, input int lim, input string nm);
    int k;
    k = 0;
    while (sb.size() > n && k < lim) begin
      tick();
      k++;
    end
    checks++;
    if (sb.size() > n) begin
      errors++;
      $display("FAIL %s: timeout, %0d pending want %0d", nm, sb.size(), n);
    end
  endtask

  // Memory model: ready after lat REQ cycles.
  initial begin
    int age;
    age       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (age >= lat) begin
          mem_ready = 1'b1;
          mem_rdata = line_of(mem_addr);
          fill_cnt++;
        end else begin
          mem_ready = 1'b0;
        end
        age++;
        req_cnt++;
      end else begin
        mem_ready = 1'b0;
        age = 0;
      end
    end
  end

  // Monitor: every loaded valid output must match the queue head.
  initial begin
    logic e;
    exp_t x;
    forever begin
      @(posedge clk);
      e = en_fetch && !reset;
      @(negedge clk);
      if (e && instr_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got pc %h instr %h want none",
                   pc_out, instruction);
        end else begin
          x = sb.pop_front();
          if (pc_out !== x.pc || instruction !== x.instr) begin
            errors++;
            $display("FAIL sb_out: got pc %h instr %h want pc %h instr %h",
                     pc_out, instruction, x.pc, x.instr);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int f0;
    logic [31:0] alt [4];
    alt[0] = 32'h1000;
    alt[1] = 32'h1040;
    alt[2] = 32'h1000;
    alt[3] = 32'h1040;

    reset         = 1'b1;
    en_fetch      = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    repeat (2) tick();

    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_block", {31'd0, block_pipe_instr_cache}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instruction, 32'h0);

    // Cold miss, then a sequential run through the line.
    reset = 1'b0;
    push(32'h1000);
    push(32'h1004);
    push(32'h1008);
    push(32'h100C);
    #1;
    chk("miss_block0", {31'd0, block_pipe_instr_cache}, 32'd1);
    chk("miss_req0", {31'd0, mem_req}, 32'd0);
    tick();
    chk("req_mem_req", {31'd0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, 32'h1000);
    chk("req_block", {31'd0, block_pipe_instr_cache}, 32'd1);
    tick();
    chk("fill_block", {31'd0, block_pipe_instr_cache}, 32'd1);
    chk("fill_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("hit_block", {31'd0, block_pipe_instr_cache}, 32'd0);
    r0 = req_cnt;
    wait_sb(3, 10, "first_hit");
    chk("first_instr", instruction, 32'hA5A5_1000);
    chk("first_pc", pc_out, 32'h1000);
    wait_sb(0, 10, "seq_run");
    chk("seq_no_req", r0, req_cnt);

    // Fetch hold during hits.
    push(32'h1010);
    push(32'h1014);
    push(32'h1018);
    wait_sb(2, 20, "hold_first");
    en_fetch = 1'b0;
    tick();
    chk("hold1_instr", instruction, 32'hA5A5_1010);
    chk("hold1_pc", pc_out, 32'h1010);
    tick();
    chk("hold2_pc", pc_out, 32'h1010);
    chk("hold2_valid", {31'd0, instr_valid}, 32'd1);
    en_fetch = 1'b1;
    wait_sb(0, 10, "hold_resume");

    // Redirect in a hit cycle to a misaligned target.
    chk("br_hit_block", {31'd0, block_pipe_instr_cache}, 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h1043;
    tick();
    branch_taken = 1'b0;
    chk("br_bubble", {31'd0, instr_valid}, 32'd0);
    chk("br_bubble_pc", pc_out, 32'h101C);
    chk("br_bubble_nop", instruction, 32'h0);
    chk("br_miss_block", {31'd0, block_pipe_instr_cache}, 32'd1);
    push(32'h1040);
    push(32'h1044);
    tick();
    chk("br_req", {31'd0, mem_req}, 32'd1);
    chk("br_addr", mem_addr, 32'h1040);
    wait_sb(0, 20, "br_fetch");

    // Alternating lines that share index 0 must refill each time.
    for (int i = 0; i < 4; i++) begin
      f0 = fill_cnt;
      branch_taken  = 1'b1;
      branch_target = alt[i];
      push(alt[i]);
      tick();
      branch_taken = 1'b0;
      wait_sb(0, 20, "alias_fetch");
      chk("alias_refill", fill_cnt, f0 + 1);
    end

    // Reset lands on the same edge as a late mem_ready.
    lat           = 1;
    branch_taken  = 1'b1;
    branch_target = 32'h10A0;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("rr_req", {31'd0, mem_req}, 32'd1);
    chk("rr_addr", mem_addr, 32'h10A0);
    tick();
    reset = 1'b1;
    #1;
    chk("rr_req_gated", {31'd0, mem_req}, 32'd0);
    chk("rr_block_gated", {31'd0, block_pipe_instr_cache}, 32'd0);
    tick();
    chk("rr_req_after", {31'd0, mem_req}, 32'd0);
    chk("rr_pc_out", pc_out, 32'h0);
    lat   = 0;
    reset = 1'b0;
    #1;
    chk("rr_first_miss", {31'd0, block_pipe_instr_cache}, 32'd1);
    push(32'h1000);
    tick();
    chk("rr_refill_addr", mem_addr, 32'h1000);
    wait_sb(0, 20, "rr_fetch");
    f0 = fill_cnt;
    branch_taken  = 1'b1;
    branch_target = 32'h10A0;
    push(32'h10A0);
    tick();
    branch_taken = 1'b0;
    chk("rr_no_line", {31'd0, block_pipe_instr_cache}, 32'd1);
    wait_sb(0, 20, "rr_10a0");
    chk("rr_refill_cnt", fill_cnt, f0 + 1);

    // PC wrap at the top of the address space.
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC);
    push(32'h0000_0000);
    tick();
    branch_taken = 1'b0;
    tick();
    chk("wrap_addr", mem_addr, 32'hFFFF_FFF0);
    wait_sb(0, 40, "wrap_fetch");
    en_fetch = 1'b0;
    repeat (3) tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
